control_unit: RTL and testbench

Multicycle control unit and register file for the 8-bit datapath, sitting directly upstream of the ALU. It fetches 8-bit instructions from instruction memory, decodes them, and drives the ALU operands and 3-bit ALU operation code. It consumes the ALU result, zero and eq outputs to write back registers, update the zero flag, and resolve branches.

---
 rtl/control_unit_pkg.sv | 32 +++
 rtl/control_unit_reg_file.sv | 21 ++
 rtl/control_unit.sv | 90 +++++++++
 tb/tb_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, ALU op codes, FSM state encoding and instruction layout for the 8-bit control unit
package control_unit_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // ALU codes for add/sub/and/or coincide with the opcodes, so ALU ops pass ir.op straight through
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_FETCH_IMM = 3'd2;
    localparam logic [2:0] S_IMM       = 3'd3;
    localparam logic [2:0] S_EXEC      = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    // instruction bits [7:1]; bit 0 is ignored and never stored
    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
    } instr_t;
endpackage

// File: rtl/control_unit_reg_file.sv
// control_unit_reg_file: 4x8 register file, two combinational read ports, one synchronous write port
//   clk, rst_n (async active-low clear), wr_en/wr_addr/wr_data write port,
//   rd_addr_a/rd_data_a and rd_addr_b/rd_data_b read ports
module control_unit_reg_file (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [1:0] rd_addr_b,
    output logic [7:0] rd_data_b
);
    logic [7:0] regs [4];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < 4; i++) regs[i] <= '0;
        else if (wr_en) regs[wr_addr] <= wr_data;
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle FSM fetching 8-bit instructions, driving the ALU and writing back the register file
//   clk, rst_n (async active-low), enable (hold everything when low)
//   imem_addr/imem_data: synchronous-read instruction memory
//   alu_a/alu_b/alu_op out, alu_result/alu_zero/alu_eq in
//   reg_wr_en/reg_wr_addr/reg_wr_data: write-back strobe, zero_flag, halted
module control_unit import control_unit_pkg::*; #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_eq,
    output logic       reg_wr_en,
    output logic [1:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       zero_flag,
    output logic       halted
);
    logic [2:0] state;
    logic [7:0] pc, imm, ra, rb;
    instr_t     ir, fetched;
    logic       is_beq, is_ldi, is_mov, in_exec;
    logic       imem_lsb_unused;

    assign fetched         = imem_data[7:1];
    assign imem_lsb_unused = imem_data[0];
    assign is_beq          = ir.op == OP_BEQ;
    assign is_ldi          = ir.op == OP_LDI;
    assign is_mov          = ir.op == OP_MOV;
    assign in_exec         = state == S_EXEC;

    control_unit_reg_file u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (reg_wr_en),
        .wr_addr   (reg_wr_addr),
        .wr_data   (reg_wr_data),
        .rd_addr_a (ir.rd),
        .rd_data_a (ra),
        .rd_addr_b (ir.rs),
        .rd_data_b (rb)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            imm       <= '0;
            zero_flag <= 1'b0;
        end else if (enable) begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= fetched;
                    pc    <= pc + 8'd1;
                    state <= fetched.op == OP_HALT ? S_HALT :
                             (fetched.op == OP_LDI || fetched.op == OP_BEQ) ? S_FETCH_IMM : S_EXEC;
                end
                S_FETCH_IMM: state <= S_IMM;
                S_IMM: begin
                    imm   <= imem_data;
                    pc    <= pc + 8'd1;
                    state <= is_ldi ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    if (!is_beq) zero_flag <= alu_zero;
                    else if (alu_eq) pc <= pc + imm;
                    state <= S_FETCH;
                end
                default: state <= state;
            endcase
        end

    assign imem_addr   = pc;
    assign halted      = state == S_HALT;
    assign alu_a       = (in_exec && is_mov) ? rb : ra;
    assign alu_b       = rb;
    assign alu_op      = !in_exec ? ALU_PASS : is_beq ? ALU_SUB : is_mov ? ALU_PASS : ir.op;
    assign reg_wr_en   = enable && ((in_exec && !is_beq) || (state == S_IMM && is_ldi));
    assign reg_wr_addr = ir.rd;
    assign reg_wr_data = in_exec ? alu_result : imem_data;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed programs with a write-back scoreboard and direct checks of pc, flags and halt
module tb_control_unit;
    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic [7:0] imem_addr, imem_data, alu_a, alu_b, alu_result, reg_wr_data;
    logic [2:0] alu_op;
    logic [1:0] reg_wr_addr;
    logic       alu_zero, alu_eq, reg_wr_en, zero_flag, halted;
    logic [7:0] mem [256];

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         e;
    } wr_t;
    wr_t sb[$];
    int  n_chk = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a;
            default: alu_result = 8'h00;
        endcase
        alu_zero = alu_result == 8'h00;
        alu_eq   = alu_a == alu_b;
    end

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_eq      (alu_eq),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .zero_flag   (zero_flag),
        .halted      (halted)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write-back monitor: every strobe must match the oldest expected write, including its edge number
    always @(negedge clk)
        if (rst_n && reg_wr_en) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", reg_wr_addr, reg_wr_data);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", reg_wr_addr, w.a);
                check("wr_data", reg_wr_data, w.d);
                if (w.e >= 0) check("wr_edge", cyc + 1, w.e);
            end
        end

    task automatic push(input logic [1:0] a, input logic [7:0] d, input int e);
        wr_t w;
        w.a = a;
        w.d = d;
        w.e = e;
        sb.push_back(w);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input int bound);
        int k = 0;
        while (!halted && k < bound) begin
            edges(1);
            k++;
        end
        check("halt_reached", halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state and immediate HALT
        hold_reset();
        #12;
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_halted", halted, 0);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_alu_op", alu_op, 3'b100);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_zero_flag", zero_flag, 0);
        release_reset();
        edges(1);
        check("halt_c1", halted, 0);
        edges(1);
        check("halt_c2", halted, 1);
        check("halt_pc", imem_addr, 8'h01);
        edges(5);
        check("halt_pc_hold", imem_addr, 8'h01);
        check("halt_hold", halted, 1);
        check("halt_sb_empty", sb.size(), 0);

        // LDI, LDI, ADD, SUB, BEQ not taken, HALT
        hold_reset();
        mem[0] = 8'hA0; mem[1] = 8'h05; mem[2] = 8'hA8; mem[3] = 8'h03;
        mem[4] = 8'h02; mem[5] = 8'h20; mem[6] = 8'hC2; mem[7] = 8'h04;
        push(2'd0, 8'h05, 4);
        push(2'd1, 8'h03, 8);
        push(2'd0, 8'h08, 11);
        push(2'd0, 8'h00, 14);
        release_reset();
        edges(11);
        check("add_zero_flag", zero_flag, 0);
        edges(3);
        check("sub_zero_flag", zero_flag, 1);
        edges(5);
        check("beq_nt_pc", imem_addr, 8'h08);
        wait_halt(10);
        check("prog_halt_pc", imem_addr, 8'h09);
        check("prog_halt_edge", cyc, 21);
        check("beq_keeps_zero", zero_flag, 1);
        check("prog_sb_empty", sb.size(), 0);

        // BEQ FE with R0==R1 loops back onto itself
        hold_reset();
        mem[0] = 8'hA0; mem[1] = 8'h03; mem[2] = 8'hA8; mem[3] = 8'h03;
        mem[4] = 8'hC2; mem[5] = 8'hFE;
        push(2'd0, 8'h03, 4);
        push(2'd1, 8'h03, 8);
        release_reset();
        edges(13);
        check("loop_pc1", imem_addr, 8'h04);
        check("loop_not_halted", halted, 0);
        edges(5);
        check("loop_pc2", imem_addr, 8'h04);
        check("loop_sb_empty", sb.size(), 0);

        // branch to FE, then BEQ at FE with imm 05 wraps to 05
        hold_reset();
        mem[0] = 8'hC0; mem[1] = 8'hFC; mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'h05;
        mem[5] = 8'hA4; mem[6] = 8'h5A;
        push(2'd0, 8'h5A, 14);
        release_reset();
        wait_halt(30);
        check("wrap_halt_pc", imem_addr, 8'h08);
        check("wrap_halt_edge", cyc, 16);
        check("wrap_sb_empty", sb.size(), 0);

        // enable low for 3 cycles during the ADD execute cycle
        hold_reset();
        mem[0] = 8'hA0; mem[1] = 8'h05; mem[2] = 8'hA8; mem[3] = 8'h03; mem[4] = 8'h02;
        push(2'd0, 8'h05, 4);
        push(2'd1, 8'h03, 8);
        push(2'd0, 8'h08, 14);
        release_reset();
        edges(10);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_wr_en", reg_wr_en, 0);
            check("stall_pc", imem_addr, 8'h05);
            edges(1);
        end
        enable = 1'b1;
        wait_halt(10);
        check("stall_halt_pc", imem_addr, 8'h06);
        check("stall_halt_edge", cyc, 16);
        check("stall_sb_empty", sb.size(), 0);

        // reset during the LDI immediate cycle aborts the write
        hold_reset();
        mem[0] = 8'hA4; mem[1] = 8'h77;
        release_reset();
        edges(3);
        check("imm_wr_en", reg_wr_en, 1);
        check("imm_wr_data", reg_wr_data, 8'h77);
        rst_n = 1'b0;
        #1;
        check("abort_pc", imem_addr, 8'h00);
        check("abort_wr_en", reg_wr_en, 0);
        mem[0] = 8'h80; mem[1] = 8'hE0;
        push(2'd0, 8'h00, 3);
        release_reset();
        wait_halt(10);
        check("abort_halt_pc", imem_addr, 8'h02);
        check("abort_halt_edge", cyc, 5);
        check("abort_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
